// File: rtl/aes_decipher_arbiter_if.sv
// Request/response bundle of aes_decipher_arbiter: per-requester ciphertext
// requests and the tagged plaintext response channel.
interface aes_decipher_arbiter_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_block;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [127:0]        rsp_block;
  logic                rsp_err;

  modport master (
    output req_valid, req_block, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_block, rsp_err
  );

  modport slave (
    input  req_valid, req_block, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_block, rsp_err
  );
endinterface

// File: rtl/aes_decipher_arbiter.sv
// Round-robin scheduler sharing one AES decipher round engine between NREQ requesters.
// Optional watchdog: define AES_DEC_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit.
module aes_decipher_arbiter #(
  parameter int NREQ           = 2,
  parameter int ID_W           = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  aes_decipher_arbiter_if.slave bus,
  input  logic                  keylen_cfg,
  input  logic                  key_ready,
  output logic                  dec_next,
  output logic                  dec_keylen,
  output logic [127:0]          dec_block,
  input  logic                  dec_ready,
  input  logic [127:0]          dec_result
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESP      = 3'd4
  } state_t;

  if (NREQ < 2 || NREQ > 4 || (2 ** ID_W) < NREQ || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("aes_decipher_arbiter: unsupported NREQ/ID_W/TIMEOUT_CYCLES");
  end

  state_t              state_r;
  logic [ID_W-1:0]     ptr_r;
  logic [NREQ-1:0]     req_ready_r;
  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [127:0]        rsp_block_r;
  logic [2*NREQ-1:0]   rot_s;
  logic                found_s;
  logic [ID_W-1:0]     winner_s;
  logic [ID_W-1:0]     next_ptr_s;
  logic [127:0]        win_block_s;

`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;
  logic             rsp_err_r;
  logic             timeout_s;
  assign timeout_s   = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_err = rsp_err_r;
`else
  assign bus.rsp_err = 1'b0;
`endif

  // Rotating the doubled valid vector by the pointer makes bit k mean "pointer + k".
  always_comb begin
    rot_s    = {bus.req_valid, bus.req_valid} >> ptr_r;
    found_s  = 1'b0;
    winner_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s  = 1'b1;
        winner_s = ID_W'((int'(ptr_r) + k) % NREQ);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Block of the current winner
  always_comb begin
    win_block_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (winner_s == ID_W'(k)) begin
        win_block_s = bus.req_block[k*128 +: 128];
      end else begin
        win_block_s = win_block_s;
      end
    end
  end

  assign next_ptr_s    = (winner_s == ID_W'(NREQ - 1)) ? '0 : winner_s + 1'b1;
  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_block = rsp_block_r;

  // Scheduling FSM; every output is a register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      req_ready_r <= '0;
      dec_next    <= 1'b0;
      dec_block   <= '0;
      dec_keylen  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_block_r <= '0;
`ifdef AES_DEC_ARB_TIMEOUT_EN
      wait_cnt_r  <= '0;
      rsp_err_r   <= 1'b0;
`endif
    end else begin
      req_ready_r <= '0;
      dec_next    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (key_ready && dec_ready && found_s) begin
            req_ready_r <= NREQ'(1'b1) << winner_s;
            dec_block   <= win_block_s;
            dec_keylen  <= keylen_cfg;
            rsp_id_r    <= winner_s;
            ptr_r       <= next_ptr_s;
            state_r     <= ISSUE;
`ifdef AES_DEC_ARB_TIMEOUT_EN
            wait_cnt_r  <= '0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          dec_next <= 1'b1;
          state_r  <= WAIT_LOW;
        end
        // The engine's ready is registered, so it is still high on the first wait cycle
        WAIT_LOW: begin
`ifdef AES_DEC_ARB_TIMEOUT_EN
          if (timeout_s) begin
            rsp_block_r <= '0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else if (!dec_ready) begin
            wait_cnt_r  <= wait_cnt_r + 1'b1;
            state_r     <= WAIT_HIGH;
          end else begin
            wait_cnt_r  <= wait_cnt_r + 1'b1;
          end
`else
          if (!dec_ready) begin
            state_r <= WAIT_HIGH;
          end else begin
            state_r <= WAIT_LOW;
          end
`endif
        end
        WAIT_HIGH: begin
          if (dec_ready) begin
            rsp_block_r <= dec_result;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
`ifdef AES_DEC_ARB_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
          end else if (timeout_s) begin
            rsp_block_r <= '0;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            wait_cnt_r  <= wait_cnt_r + 1'b1;
`else
          end else begin
            state_r     <= WAIT_HIGH;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
`ifdef AES_DEC_ARB_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
`endif
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decipher_arbiter.sv
// Self-checking bench for aes_decipher_arbiter: known-answer engine model, a
// scheduling scoreboard checked every cycle, and directed scenarios with literal expectations.
module tb_aes_decipher_arbiter;
  localparam int NREQ = 2;
  localparam int ID_W = 1;
`ifdef AES_DEC_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 255;
`endif
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] SCRAMB = 128'h0123456789abcdef0123456789abcdef;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         keylen_cfg;
  logic         key_ready;
  logic         dec_next;
  logic         dec_keylen;
  logic [127:0] dec_block;
  logic         dec_ready;
  logic [127:0] dec_result;

  int tests = 0;
  int fails = 0;

  aes_decipher_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  aes_decipher_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .keylen_cfg (keylen_cfg),
    .key_ready  (key_ready),
    .dec_next   (dec_next),
    .dec_keylen (dec_keylen),
    .dec_block  (dec_block),
    .dec_ready  (dec_ready),
    .dec_result (dec_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Known answers for the FIPS-197 vectors, a fixed scramble for any other block
  function automatic logic [127:0] ref_decrypt(input logic kl, input logic [127:0] c);
    if (!kl && c == CT128) return PT;
    else if (kl && c == CT256) return PT;
    else return ~c ^ SCRAMB ^ {127'd0, kl};
  endfunction

  int           eng_lat   = 3;
  bit           eng_stuck = 1'b0;
  int           eng_cnt;
  logic [127:0] eng_in;
  logic         eng_kl;

  // Engine model: registered ready (reset 1), fixed latency; stuck mode ignores dec_next
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_ready  <= 1'b1;
      dec_result <= '0;
      eng_cnt    <= 0;
      eng_in     <= '0;
      eng_kl     <= 1'b0;
    end else if (dec_ready) begin
      if (dec_next && !eng_stuck) begin
        dec_ready <= 1'b0;
        eng_cnt   <= eng_lat;
        eng_in    <= dec_block;
        eng_kl    <= dec_keylen;
      end
    end else if (eng_cnt <= 1) begin
      dec_ready  <= 1'b1;
      dec_result <= ref_decrypt(eng_kl, eng_in);
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Scoreboard state
  logic [NREQ-1:0]     p_valid;
  logic [NREQ*128-1:0] p_block;
  logic                p_kl;
  logic                p_key;
  int                  m_ptr = 0;
  int                  m_w;
  bit                  pend = 1'b0;
  int                  j_id;
  logic [127:0]        j_blk;
  logic                j_kl;
  bit                  j_err;
  int                  nexts;
  int                  n_grant = 0;
  int                  n_next  = 0;
  int                  n_rsp   = 0;
  int                  grant_log[$];
  logic [127:0]        m_exp;

  // Compare process: inputs seen one sample earlier are what the DUT decided on
  always @(negedge clk) begin
    if (!reset_n) begin
      pend  = 1'b0;
      m_ptr = 0;
    end else begin
      if (bus.req_ready != '0) begin
        m_w = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_w < 0 && p_valid[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
        chk("grant_while_busy", pend, 1'b0);
        chk("grant_key_ready", p_key, 1'b1);
        chk("grant_has_request", (m_w >= 0), 1'b1);
        if (m_w >= 0) begin
          chk("grant_winner", bus.req_ready, 128'd1 << m_w);
          pend  = 1'b1;
          j_id  = m_w;
          j_blk = p_block[m_w*128 +: 128];
          j_kl  = p_kl;
          j_err = eng_stuck;
          nexts = 0;
          m_ptr = (m_w + 1) % NREQ;
          n_grant++;
          grant_log.push_back(m_w);
        end
      end
      if (dec_next) begin
        n_next++;
        nexts++;
        chk("next_in_job", pend, 1'b1);
        chk("next_once", nexts, 1);
      end
      if (pend) begin
        chk("dec_block_held", dec_block, j_blk);
        chk("dec_keylen_held", dec_keylen, j_kl);
      end
      if (bus.rsp_valid) begin
        m_exp = j_err ? 128'd0 : ref_decrypt(j_kl, j_blk);
        chk("rsp_in_job", pend, 1'b1);
        chk("rsp_id", bus.rsp_id, j_id);
        chk("rsp_block", bus.rsp_block, m_exp);
        chk("rsp_err", bus.rsp_err, j_err);
        chk("rsp_after_next", nexts, 1);
        if (bus.rsp_ready) begin
          pend = 1'b0;
          n_rsp++;
        end
      end
    end
    p_valid = bus.req_valid;
    p_block = bus.req_block;
    p_kl    = keylen_cfg;
    p_key   = key_ready;
  end

  int quota [NREQ];

  // One cycle; each requester drops valid once its quota of accepts is used up
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        quota[i]--;
        if (quota[i] <= 0) bus.req_valid[i] = 1'b0;
        else bus.req_block[i*128 +: 128] = bus.req_block[i*128 +: 128] ^ {96'd0, 32'(quota[i] + 7)};
      end
    end
  endtask

  function automatic int gl(input int i);
    if (i < grant_log.size()) return grant_log[i];
    else return -1;
  endfunction

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!bus.rsp_valid && n < 200) begin step(); n++; end
    chk(nm, bus.rsp_valid, 1'b1);
  endtask

  task automatic wait_rsps(input string nm, input int target);
    int n = 0;
    while (n_rsp < target && n < 400) begin step(); n++; end
    chk(nm, (n_rsp >= target), 1'b1);
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    while ((pend || bus.rsp_valid) && n < 300) begin step(); n++; end
    chk(nm, (pend || bus.rsp_valid), 1'b0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_req_ready"}, bus.req_ready, 0);
    chk({nm, "_dec_next"}, dec_next, 0);
    chk({nm, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({nm, "_rsp_err"}, bus.rsp_err, 0);
    chk({nm, "_rsp_id"}, bus.rsp_id, 0);
    chk({nm, "_rsp_block"}, bus.rsp_block, 0);
    chk({nm, "_dec_block"}, dec_block, 0);
    chk({nm, "_dec_keylen"}, dec_keylen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int x0;
    int r0;
    int n;
    int rr_exp [4] = '{0, 1, 0, 1};

    reset_n        = 1'b1;
    bus.req_valid  = '0;
    bus.req_block  = '0;
    bus.rsp_ready  = 1'b0;
    keylen_cfg     = 1'b0;
    key_ready      = 1'b0;
    quota          = '{0, 0};
    #2 reset_n = 1'b0;
    #1;
    check_reset("reset");
    repeat (2) step();
    reset_n = 1'b1;

    // FIPS-197 AES-128 vector from requester 0
    key_ready = 1'b1;
    bus.rsp_ready = 1'b1;
    quota[0] = 1;
    bus.req_block[127:0] = CT128;
    bus.req_valid[0] = 1'b1;
    g0 = n_grant;
    x0 = n_next;
    wait_rsp("t1_rsp");
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_block", bus.rsp_block, PT);
    chk("t1_err", bus.rsp_err, 0);
    wait_quiet("t1_quiet");
    chk("t1_grants", n_grant - g0, 1);
    chk("t1_nexts", n_next - x0, 1);
    chk("t1_who", gl(g0), 0);

    // AES-256 vector from requester 1; keylen_cfg flips after the grant
    keylen_cfg = 1'b1;
    quota[1] = 1;
    bus.req_block[255:128] = CT256;
    bus.req_valid[1] = 1'b1;
    n = 0;
    while (bus.req_ready[1] !== 1'b1 && n < 50) begin step(); n++; end
    chk("t2_grant", bus.req_ready[1], 1'b1);
    keylen_cfg = 1'b0;
    step();
    step();
    chk("t2_keylen", dec_keylen, 1'b1);
    wait_rsp("t2_rsp");
    chk("t2_id", bus.rsp_id, 1);
    chk("t2_block", bus.rsp_block, PT);
    wait_quiet("t2_quiet");

    // Round robin: both requesters hold valid for two jobs each
    g0 = n_grant;
    quota = '{2, 2};
    bus.req_block = {128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678};
    bus.req_valid = 2'b11;
    n = 0;
    while (n_grant < g0 + 4 && n < 400) begin step(); n++; end
    wait_quiet("t3_quiet");
    chk("t3_count", n_grant - g0, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), gl(g0 + i), rr_exp[i]);

    // Backpressure: response held 20 cycles, no new grant meanwhile
    bus.rsp_ready = 1'b0;
    g0 = n_grant;
    r0 = n_rsp;
    quota = '{1, 1};
    bus.req_block = {128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, 128'ha5a5_a5a5_5a5a_5a5a_ffff_0000_ffff_0000};
    bus.req_valid = 2'b11;
    wait_rsp("t4_rsp");
    repeat (20) step();
    chk("t4_no_grant", n_grant - g0, 1);
    chk("t4_held", bus.rsp_valid, 1'b1);
    chk("t4_id", bus.rsp_id, 0);
    bus.rsp_ready = 1'b1;
    wait_rsps("t4_both", r0 + 2);
    chk("t4_order0", gl(g0), 0);
    chk("t4_order1", gl(g0 + 1), 1);

    // Key gating: no grant for 50 cycles while key_ready is low
    key_ready = 1'b0;
    g0 = n_grant;
    r0 = n_rsp;
    quota[0] = 1;
    bus.req_valid[0] = 1'b1;
    repeat (50) step();
    chk("t4_gate", n_grant - g0, 0);
    key_ready = 1'b1;
    wait_rsps("t4_ungate", r0 + 1);
    chk("t4_gate_who", gl(g0), 0);

    // Reset while waiting on the engine
    eng_lat = 10;
    g0 = n_grant;
    quota[0] = 1;
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (!(n_grant > g0 && dec_ready == 1'b0) && n < 100) begin step(); n++; end
    chk("t5_busy", dec_ready, 1'b0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_reset("t5_reset");
    step();
    step();
    reset_n = 1'b1;
    eng_lat = 3;
    chk("t5_no_stale", bus.rsp_valid, 1'b0);
    g0 = n_grant;
    r0 = n_rsp;
    quota = '{1, 1};
    bus.req_valid = 2'b11;
    wait_rsps("t5_after", r0 + 2);
    chk("t5_first", gl(g0), 0);
    chk("t5_second", gl(g0 + 1), 1);

`ifdef AES_DEC_ARB_TIMEOUT_EN
    // Watchdog: engine never drops ready
    eng_stuck = 1'b1;
    quota[0] = 1;
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (!dec_next && n < 50) begin step(); n++; end
    chk("t6_next", dec_next, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin step(); n++; end
    chk("t6_latency", n, 16);
    chk("t6_err", bus.rsp_err, 1'b1);
    chk("t6_block", bus.rsp_block, 0);
    chk("t6_id", bus.rsp_id, 0);
    wait_quiet("t6_quiet");
    eng_stuck = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
